cyclic_lamp: RTL and testbench
==============================

CYCLIC_LAMP -- requirements
Module: cyclic_lamp

Interface
REQ-001 Parameter RED_CYCLES, default 1, rising clock edges the red phase lasts (legal 1..2^CNT_W).
REQ-002 Parameter GREEN_CYCLES, default 1, rising clock edges the green phase lasts (legal 1..2^CNT_W).
REQ-003 Parameter YELLOW_CYCLES, default 1, rising clock edges the yellow phase lasts (legal 1..2^CNT_W).
REQ-004 Parameter CNT_W, default 8, width of the internal phase-duration counter.
REQ-005 Port clock, input, 1, single clock; all state changes on rising edge.
REQ-006 Port reset, input, 1, asynchronous active-high reset.
REQ-007 Port light, output, 3 declared [0:2], one-hot lamp drive: light[0] red, light[1] green, light[2] yellow.
REQ-008 Lamp encodings as written MSB-first: red = 3'b100, green = 3'b010, yellow = 3'b001.
REQ-009 The block SHALL use one clock and an asynchronous active-high reset; clock port named clock, reset port named reset.

Function
REQ-010 Three-state FSM: RED, GREEN, YELLOW; fixed cycle RED -> GREEN -> YELLOW -> RED.
REQ-011 light SHALL be a registered output decoded from state only; no combinational path from any input.
REQ-012 light SHALL always be exactly one-hot; 3'b000 and multi-hot values never appear after reset.
REQ-013 Internal counter cnt, CNT_W bits, counts rising edges spent in the current phase.
REQ-014 On each rising edge with reset low: if cnt equals current phase's CYCLES-1, advance to next state and set cnt to 0; else increment cnt, state unchanged.
REQ-015 Each phase SHALL therefore hold for exactly its CYCLES rising edges, with the first edge after reset release counting as edge 1 of RED.
REQ-016 With all defaults (1,1,1) light SHALL change on every rising edge: 100, 010, 001, 100, ...
REQ-017 Full cycle period SHALL be RED_CYCLES+GREEN_CYCLES+YELLOW_CYCLES rising edges, repeating indefinitely without drift.
REQ-018 cnt SHALL never wrap: the phase-end compare precedes increment, so CYCLES = 2^CNT_W is reachable and terminates correctly.
REQ-019 Any unreachable state encoding SHALL transition to RED with cnt = 0 on the next rising edge.
REQ-020 Parameters outside legal range (0 or > 2^CNT_W) SHALL be flagged by an elaboration-time check (simulation error message); no runtime behaviour defined for them.

Reset
REQ-021 reset high SHALL immediately (no clock required) force state RED, light = 3'b100, cnt = 0.
REQ-022 While reset is high, light SHALL remain 3'b100 regardless of clock activity.
REQ-023 Reset asserted mid-phase (any state, any cnt) SHALL abandon that phase; after release, sequence restarts with a full RED_CYCLES red phase.
REQ-024 Reset release is synchronous-safe only if deasserted away from a rising edge; the bench SHALL deassert reset on a falling clock edge.
REQ-025 Before the first reset assertion, light is undefined; the bench SHALL assert reset at time 0 for at least one clock period.

Verification
REQ-026 Defaults, reset high 2 cycles then low -> light 100 during reset, then 010, 001, 100, 010, 001 on successive rising edges.
REQ-027 RED=3, GREEN=2, YELLOW=1 -> after release: 100 x3 edges, 010 x2, 001 x1, then 100 again; period 6 edges, checked over 3 periods.
REQ-028 Mid-phase reset: RED=3,GREEN=4,YELLOW=2, assert reset asynchronously during 2nd GREEN edge -> light 100 within same time step without clock edge; after release full 3-edge red.
REQ-029 Boundary: CNT_W=2, GREEN_CYCLES=4 -> green lasts exactly 4 edges, no counter wrap or early exit.
REQ-030 Continuous checker every edge after reset: light in {100,010,001} and only legal transitions 100->010->001->100 occur; any violation is a failure.
REQ-031 Bench SHALL print the lamp name (Red/Green/Yellow) and light value with time on every light change for log review.

Source files
------------

// File: rtl/cyclic_lamp.sv
// Purpose: fixed-cycle traffic lamp sequencer RED -> GREEN -> YELLOW -> RED with per-phase durations.
// Latency: light is registered from next-state decode, so it changes on the rising edge that enters a phase.
// Backpressure: none; free-running sequencer with no handshake.
//
// Ports:
//   clock - single clock; all state changes occur on its rising edge
//   reset - asynchronous active-high reset; immediately forces RED, light = 3'b100, cnt = 0
//   light - one-hot lamp drive declared [0:2]: light[0] red, light[1] green, light[2] yellow
//           (written MSB-first: red = 3'b100, green = 3'b010, yellow = 3'b001)
module cyclic_lamp #(
  parameter int RED_CYCLES    = 1,
  parameter int GREEN_CYCLES  = 1,
  parameter int YELLOW_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic       clock,
  input  logic       reset,
  output logic [0:2] light
);

  // Largest legal phase length: the counter holds CYCLES-1, which fits in CNT_W bits.
  localparam longint MAX_CYCLES = longint'(1) << CNT_W;

  // Elaboration-time range checks; illegal lengths have no defined runtime behaviour.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("cyclic_lamp: CNT_W=%0d must be at least 1", CNT_W);
  end
  if (RED_CYCLES < 1 || longint'(RED_CYCLES) > MAX_CYCLES) begin : g_bad_red
    $error("cyclic_lamp: RED_CYCLES=%0d outside 1..2^CNT_W", RED_CYCLES);
  end
  if (GREEN_CYCLES < 1 || longint'(GREEN_CYCLES) > MAX_CYCLES) begin : g_bad_green
    $error("cyclic_lamp: GREEN_CYCLES=%0d outside 1..2^CNT_W", GREEN_CYCLES);
  end
  if (YELLOW_CYCLES < 1 || longint'(YELLOW_CYCLES) > MAX_CYCLES) begin : g_bad_yellow
    $error("cyclic_lamp: YELLOW_CYCLES=%0d outside 1..2^CNT_W", YELLOW_CYCLES);
  end

  // Terminal counts. Comparing against CYCLES-1 before incrementing means a phase of
  // exactly 2^CNT_W edges ends at the all-ones count and the counter never wraps.
  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);

  localparam logic [0:2] LAMP_RED    = 3'b100;
  localparam logic [0:2] LAMP_GREEN  = 3'b010;
  localparam logic [0:2] LAMP_YELLOW = 3'b001;

  typedef enum logic [1:0] {
    ST_RED    = 2'b00,
    ST_GREEN  = 2'b01,
    ST_YELLOW = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [0:2]       light_nxt;

  // Next-state and counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    case (state)
      ST_RED: begin
        if (cnt == RED_LAST) begin
          state_nxt = ST_GREEN;
          cnt_nxt   = '0;
        end
      end
      ST_GREEN: begin
        if (cnt == GREEN_LAST) begin
          state_nxt = ST_YELLOW;
          cnt_nxt   = '0;
        end
      end
      ST_YELLOW: begin
        if (cnt == YELLOW_LAST) begin
          state_nxt = ST_RED;
          cnt_nxt   = '0;
        end
      end
      default: begin
        // Unused encoding (e.g. after an upset): recover to the start of red.
        state_nxt = ST_RED;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Lamp decode from the next state so the registered light tracks state with no
  // extra cycle and no path from any input to the output.
  always_comb begin
    light_nxt = LAMP_RED;
    case (state_nxt)
      ST_RED:    light_nxt = LAMP_RED;
      ST_GREEN:  light_nxt = LAMP_GREEN;
      ST_YELLOW: light_nxt = LAMP_YELLOW;
      default:   light_nxt = LAMP_RED;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_RED;
      cnt   <= '0;
      light <= LAMP_RED;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      light <= light_nxt;
    end
  end

endmodule

// File: tb/tb_cyclic_lamp.sv
// Purpose: randomized self-checking bench for cyclic_lamp over four parameter sets.
// Latency: the reference model predicts light from the count of edges since reset release.
// Backpressure: not applicable; resets are pulsed asynchronously at random points.
module tb_cyclic_lamp;

  localparam int NDUT = 4;
  // Phase lengths per instance: defaults, 3/2/1, 3/4/2, and a CNT_W=2 part whose
  // green phase of 4 edges uses the full counter range.
  localparam int PR [NDUT] = '{1, 3, 3, 1};
  localparam int PG [NDUT] = '{1, 2, 4, 4};
  localparam int PY [NDUT] = '{1, 1, 2, 2};

  logic       clock = 1'b0;
  logic [3:0] rst;
  logic [0:2] light0, light1, light2, light3;
  logic [2:0] lt [NDUT];

  int         k [NDUT];
  logic [2:0] prev [NDUT];
  bit         prev_ok [NDUT];
  int         n_pass  = 0;
  int         n_total = 0;

  always #5 clock = ~clock;

  cyclic_lamp dut0 (.clock(clock), .reset(rst[0]), .light(light0));
  cyclic_lamp #(.RED_CYCLES(3), .GREEN_CYCLES(2), .YELLOW_CYCLES(1)) dut1
    (.clock(clock), .reset(rst[1]), .light(light1));
  cyclic_lamp #(.RED_CYCLES(3), .GREEN_CYCLES(4), .YELLOW_CYCLES(2)) dut2
    (.clock(clock), .reset(rst[2]), .light(light2));
  cyclic_lamp #(.RED_CYCLES(1), .GREEN_CYCLES(4), .YELLOW_CYCLES(2), .CNT_W(2)) dut3
    (.clock(clock), .reset(rst[3]), .light(light3));

  assign lt[0] = light0;
  assign lt[1] = light1;
  assign lt[2] = light2;
  assign lt[3] = light3;

  // Reference: k = rising edges seen with reset low since the last reset.
  always @(posedge clock) begin
    for (int i = 0; i < NDUT; i++) begin
      if (rst[i]) k[i] = 0;
      else        k[i] = k[i] + 1;
    end
  end

  // After kk edges the lamp shows the phase that edge kk+1 belongs to in the period.
  function automatic logic [2:0] model_light(input int i, input int kk);
    int p;
    p = kk % (PR[i] + PG[i] + PY[i]);
    if (p < PR[i])              return 3'b100;
    else if (p < PR[i] + PG[i]) return 3'b010;
    else                        return 3'b001;
  endfunction

  function automatic logic legal_step(input logic [2:0] a, input logic [2:0] b);
    return (a == b) || (a == 3'b100 && b == 3'b010) ||
           (a == 3'b010 && b == 3'b001) || (a == 3'b001 && b == 3'b100);
  endfunction

  function automatic string lamp_name(input logic [2:0] v);
    case (v)
      3'b100:  return "Red";
      3'b010:  return "Green";
      3'b001:  return "Yellow";
      default: return "none";
    endcase
  endfunction

  always @(light0) $display("%0t dut0 %s light=%b", $time, lamp_name(light0), light0);
  always @(light1) $display("%0t dut1 %s light=%b", $time, lamp_name(light1), light1);
  always @(light2) $display("%0t dut2 %s light=%b", $time, lamp_name(light2), light2);
  always @(light3) $display("%0t dut3 %s light=%b", $time, lamp_name(light3), light3);

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
  endtask

  // Called away from the rising edge: model compare, one-hot and legal-transition checks.
  task automatic check_all();
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("model%0d_k%0d", i, k[i]), lt[i], model_light(i, k[i]));
      check($sformatf("onehot%0d", i), {2'b00, $onehot(lt[i])}, 3'b001);
      if (prev_ok[i])
        check($sformatf("trans%0d_%b", i, prev[i]), {2'b00, legal_step(prev[i], lt[i])}, 3'b001);
      prev[i]    = lt[i];
      prev_ok[i] = 1'b1;
    end
  endtask

  // Assert reset on instance i between edges and confirm the lamp goes red without a clock.
  task automatic async_reset(input int i, input int off);
    #(off);
    rst[i]     = 1'b1;
    k[i]       = 0;
    prev_ok[i] = 1'b0;
    #1;
    check($sformatf("async_rst%0d", i), lt[i], 3'b100);
  endtask

  initial begin
    int n;
    int sel;
    int off;
    int hold;

    rst = 4'hF;
    for (int i = 0; i < NDUT; i++) begin
      k[i]       = 0;
      prev[i]    = 3'b100;
      prev_ok[i] = 1'b0;
    end

    // Reset held for two clock periods; light must stay red throughout.
    repeat (2) begin
      @(negedge clock);
      check_all();
    end
    rst = 4'h0;

    // Three full 6-edge periods for the 3/2/1 instance; defaults toggle every edge.
    repeat (18) begin
      @(negedge clock);
      check_all();
    end

    // Mid-phase reset on the 3/4/2 instance after its second green edge.
    n = 0;
    while ((k[2] % 9) != 4 && n < 20) begin
      @(negedge clock);
      check_all();
      n++;
    end
    check("dut2_green_before_rst", lt[2], 3'b010);
    async_reset(2, 2);
    repeat (2) begin
      @(negedge clock);
      check_all();
    end
    rst[2] = 1'b0;
    // Full red of 3 edges then green, checked by the model.
    repeat (12) begin
      @(negedge clock);
      check_all();
    end

    // Randomized run lengths and asynchronous reset pulses at random offsets.
    repeat (40) begin
      n = $urandom_range(1, 30);
      repeat (n) begin
        @(negedge clock);
        check_all();
      end
      sel = $urandom_range(0, NDUT - 1);
      // Offsets 1..3 or 6..8 ns after the falling edge keep the +1 sample off a rising edge.
      off = $urandom_range(1, 6);
      if (off > 3) off = off + 2;
      async_reset(sel, off);
      hold = $urandom_range(1, 3);
      repeat (hold) begin
        @(negedge clock);
        check_all();
      end
      rst[sel] = 1'b0;
    end

    repeat (20) begin
      @(negedge clock);
      check_all();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
